// File: rtl/rptr_empty.sv
// Read-side pointer and empty/level logic for an asynchronous FIFO.
// Syncs the Gray write pointer into RCLK and owns the read pointer, read data register and flags.
module rptr_empty #(
  parameter int unsigned DATA_SIZE = 16,
  parameter int unsigned ADDR_SIZE = 4,
  parameter int unsigned AE_THRESH = 1
) (
  input  logic                 RCLK,
  input  logic                 RRST_N,
  input  logic                 RINC,
  input  logic [ADDR_SIZE:0]   WPTR_GRAY,
  input  logic [DATA_SIZE-1:0] RAM_RDATA,
  output logic [ADDR_SIZE-1:0] RADDR,
  output logic [ADDR_SIZE:0]   RPTR_GRAY,
  output logic [DATA_SIZE-1:0] RDATA,
  output logic                 RVALID,
  output logic                 REMPTY,
  output logic                 RAEMPTY,
  output logic [ADDR_SIZE:0]   RLEVEL,
  output logic                 RUNDERFLOW
);

  localparam int unsigned PW = ADDR_SIZE + 1;
  localparam logic [PW-1:0] AeThresh = PW'(AE_THRESH);

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] wq1_q, wq2_q;
  logic [PW-1:0] rbin_q, rbin_d;
  logic [PW-1:0] rgray_q, rgray_d;
  logic [PW-1:0] level_d;
  logic [DATA_SIZE-1:0] rdata_q, rdata_d;
  logic          rvalid_q, rempty_q, raempty_q, runderflow_q;
  logic [PW-1:0] rlevel_q;
  logic          ren;

  always_comb begin
    ren     = RINC & ~rempty_q;
    rbin_d  = rbin_q + {{ADDR_SIZE{1'b0}}, ren};
    rgray_d = (rbin_d >> 1) ^ rbin_d;
    // Compared against the current wq2; a write only shows up once it has crossed both flops.
    level_d = gray2bin(wq2_q) - rbin_d;
    rdata_d = ren ? RAM_RDATA : rdata_q;
  end

  always_ff @(posedge RCLK) begin
    if (!RRST_N) begin
      wq1_q        <= '0;
      wq2_q        <= '0;
      rbin_q       <= '0;
      rgray_q      <= '0;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
      rempty_q     <= 1'b1;
      raempty_q    <= 1'b1;
      rlevel_q     <= '0;
      runderflow_q <= 1'b0;
    end else begin
      wq1_q        <= WPTR_GRAY;
      wq2_q        <= wq1_q;
      rbin_q       <= rbin_d;
      rgray_q      <= rgray_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= ren;
      rempty_q     <= (rgray_d == wq2_q);
      raempty_q    <= (level_d <= AeThresh);
      rlevel_q     <= level_d;
      runderflow_q <= RINC & rempty_q;
    end
  end

  assign RADDR      = rbin_q[ADDR_SIZE-1:0];
  assign RPTR_GRAY  = rgray_q;
  assign RDATA      = rdata_q;
  assign RVALID     = rvalid_q;
  assign REMPTY     = rempty_q;
  assign RAEMPTY    = raempty_q;
  assign RLEVEL     = rlevel_q;
  assign RUNDERFLOW = runderflow_q;

endmodule

// File: tb/tb_rptr_empty.sv
// Bench for rptr_empty: count-based reference model checked every cycle, plus directed literals.
module tb_rptr_empty;

  logic        clk = 1'b0;
  logic        rst_n, rinc;
  logic [4:0]  wptr_gray;
  logic [15:0] ram_rdata;
  logic [3:0]  raddr;
  logic [4:0]  rptr_gray;
  logic [15:0] rdata;
  logic        rvalid, rempty, raempty, runderflow;
  logic [4:0]  rlevel;

  int          wbin;         // binary write count driven as Gray
  logic [15:0] mem [16];
  int          vectors = 0;
  int          errors = 0;
  int          pulses = 0;

  assign wptr_gray = 5'(wbin ^ (wbin >> 1));
  assign ram_rdata = mem[raddr];

  rptr_empty dut (
    .RCLK(clk), .RRST_N(rst_n), .RINC(rinc), .WPTR_GRAY(wptr_gray), .RAM_RDATA(ram_rdata),
    .RADDR(raddr), .RPTR_GRAY(rptr_gray), .RDATA(rdata), .RVALID(rvalid), .REMPTY(rempty),
    .RAEMPTY(raempty), .RLEVEL(rlevel), .RUNDERFLOW(runderflow)
  );

  always #5 clk = ~clk;

  // Reference model in terms of word counts: reads done, writes seen two edges late.
  bit          m_ok = 0;
  int          m_rd, m_s1, m_s2, m_level;
  logic [15:0] m_rdata;
  bit          m_rvalid, m_empty, m_uf;

  always @(posedge clk) begin
    bit acc;
    int rd_n;
    if (!rst_n) begin
      m_ok <= 1; m_rd <= 0; m_s1 <= 0; m_s2 <= 0; m_level <= 0;
      m_rdata <= '0; m_rvalid <= 0; m_empty <= 1; m_uf <= 0;
    end else begin
      acc  = rinc && !m_empty;
      rd_n = (m_rd + int'(acc)) % 32;
      if (acc) m_rdata <= mem[m_rd % 16];
      m_rvalid <= acc;
      m_uf     <= rinc && m_empty;
      m_level  <= (m_s2 - rd_n + 32) % 32;
      m_empty  <= ((m_s2 - rd_n + 32) % 32) == 0;
      m_rd     <= rd_n;
      m_s2     <= m_s1;
      m_s1     <= wbin % 32;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_ok) begin
      chk("m_raddr", int'(raddr), m_rd % 16);
      chk("m_rptr", int'(rptr_gray), m_rd ^ (m_rd >> 1));
      chk("m_rdata", int'(rdata), int'(m_rdata));
      chk("m_rvalid", int'(rvalid), int'(m_rvalid));
      chk("m_rempty", int'(rempty), int'(m_empty));
      chk("m_raempty", int'(raempty), int'(m_level <= 1));
      chk("m_rlevel", int'(rlevel), m_level);
      chk("m_uflow", int'(runderflow), int'(m_uf));
      chk("m_consist", int'(rempty), int'(rlevel == 0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rvalid) pulses++;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'h1000 + 16'(i);
    mem[0] = 16'hA5A5;
    rst_n = 0; rinc = 0; wbin = 0;
    tick(); tick();
    chk("rst_raddr", int'(raddr), 0);
    chk("rst_rptr", int'(rptr_gray), 0);
    chk("rst_empty", int'(rempty), 1);
    chk("rst_aempty", int'(raempty), 1);
    chk("rst_level", int'(rlevel), 0);
    chk("rst_rvalid", int'(rvalid), 0);
    rst_n = 1;
    tick(); tick();

    // One write crosses the synchronizer: visible at the third edge only.
    wbin = 1;
    tick();
    chk("w1_e1_empty", int'(rempty), 1);
    tick();
    chk("w1_e2_empty", int'(rempty), 1);
    chk("w1_e2_level", int'(rlevel), 0);
    tick();
    chk("w1_e3_empty", int'(rempty), 0);
    chk("w1_e3_level", int'(rlevel), 1);
    chk("w1_e3_aempty", int'(raempty), 1);

    // Read the single word.
    rinc = 1;
    tick();
    rinc = 0;
    chk("rd_data", int'(rdata), 16'hA5A5);
    chk("rd_valid", int'(rvalid), 1);
    chk("rd_raddr", int'(raddr), 1);
    chk("rd_rptr", int'(rptr_gray), 1);
    chk("rd_empty", int'(rempty), 1);
    chk("rd_level", int'(rlevel), 0);
    tick();
    chk("rd_valid_off", int'(rvalid), 0);

    // Underflow attempt.
    rinc = 1;
    tick();
    rinc = 0;
    chk("uf_pulse", int'(runderflow), 1);
    chk("uf_raddr", int'(raddr), 1);
    chk("uf_rptr", int'(rptr_gray), 1);
    chk("uf_rdata", int'(rdata), 16'hA5A5);
    chk("uf_rvalid", int'(rvalid), 0);
    tick();
    chk("uf_off", int'(runderflow), 0);

    // Full FIFO from a clean pointer, then drain all 16 words.
    rst_n = 0; wbin = 16;
    tick();
    rst_n = 1;
    tick(); tick(); tick();
    chk("full_level", int'(rlevel), 16);
    chk("full_aempty", int'(raempty), 0);
    chk("full_empty", int'(rempty), 0);
    pulses = 0;
    rinc = 1;
    for (int i = 0; i < 16; i++) tick();
    rinc = 0;
    chk("drain_raddr", int'(raddr), 0);
    chk("drain_rptr", int'(rptr_gray), 5'b11000);
    chk("drain_empty", int'(rempty), 1);
    chk("drain_level", int'(rlevel), 0);
    chk("drain_pulses", pulses, 16);
    tick();

    // Reset in the middle of reading.
    rst_n = 0; wbin = 10;
    tick();
    rst_n = 1;
    tick(); tick(); tick();
    chk("mid_level0", int'(rlevel), 10);
    rinc = 1;
    for (int i = 0; i < 7; i++) tick();
    chk("mid_raddr", int'(raddr), 7);
    chk("mid_level", int'(rlevel), 3);
    rst_n = 0;
    tick();
    rst_n = 1; rinc = 0;
    chk("mid_rst_raddr", int'(raddr), 0);
    chk("mid_rst_empty", int'(rempty), 1);
    chk("mid_rst_level", int'(rlevel), 0);
    tick(); tick();
    chk("mid_e2_empty", int'(rempty), 1);
    tick();
    chk("mid_e3_empty", int'(rempty), 0);
    chk("mid_e3_level", int'(rlevel), 10);

    // Concurrent reads and single-step write updates, then drain past empty.
    rinc = 1;
    for (int i = 0; i < 12; i++) begin
      wbin = (wbin + 1) % 32;
      tick();
    end
    for (int i = 0; i < 20; i++) tick();
    rinc = 0;
    chk("final_empty", int'(rempty), 1);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/rptr_empty.md
RPTR_EMPTY -- requirements
Module: rptr_empty

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 16, which is the word width.
REQ-002 SHALL have parameter ADDR_SIZE, default 4, which sets the depth to 2**ADDR_SIZE words and the pointer width to ADDR_SIZE+1 bits.
REQ-003 SHALL have parameter AE_THRESH, default 1, which is the almost-empty level threshold.
REQ-004 SHALL have port RCLK, input, width 1: the read-domain clock and the only clock; all logic is on the rising edge.
REQ-005 SHALL have port RRST_N, input, width 1: reset, synchronous and active-low.
REQ-006 SHALL have port RINC, input, width 1: read request for this cycle.
REQ-007 SHALL have port WPTR_GRAY, input, width ADDR_SIZE+1: Gray-coded write pointer, asynchronous to RCLK.
REQ-008 SHALL have port RAM_RDATA, input, width DATA_SIZE: combinational RAM read data for the word at RADDR.
REQ-009 SHALL have port RADDR, output, width ADDR_SIZE: RAM read address.
REQ-010 SHALL have port RPTR_GRAY, output, width ADDR_SIZE+1: registered Gray read pointer, sent to the write domain.
REQ-011 SHALL have port RDATA, output, width DATA_SIZE: registered read data.
REQ-012 SHALL have port RVALID, output, width 1: RDATA is valid this cycle.
REQ-013 SHALL have port REMPTY, output, width 1: registered empty flag.
REQ-014 SHALL have port RAEMPTY, output, width 1: registered almost-empty flag.
REQ-015 SHALL have port RLEVEL, output, width ADDR_SIZE+1: registered fill-level estimate.
REQ-016 SHALL have port RUNDERFLOW, output, width 1: one-cycle pulse on a rejected read.

Function
REQ-017 SHALL pass WPTR_GRAY through a two-flop synchronizer, WQ1 then WQ2, and use only WQ2 in read-domain logic.
REQ-018 SHALL accept a read when RINC=1 and REMPTY=0; the read-enable signal is RINC & !REMPTY.
REQ-019 SHALL compute the next binary pointer as RBIN + the read-enable signal, modulo 2**(ADDR_SIZE+1), wrapping silently.
REQ-020 SHALL compute the next Gray pointer as (next binary pointer >> 1) ^ next binary pointer, and register it into RPTR_GRAY each cycle.
REQ-021 SHALL drive RADDR from RBIN[ADDR_SIZE-1:0] of the registered pointer.
REQ-022 SHALL register REMPTY as (next Gray pointer == WQ2), so it asserts in the same edge that consumes the last word.
REQ-023 SHALL, on an accepted read, load RDATA with RAM_RDATA and set RVALID=1 for exactly one cycle after the edge, giving a latency of 1 RCLK.
REQ-024 SHALL hold RDATA when no read is accepted and drive RVALID=0.
REQ-025 SHALL, on RINC=1 while REMPTY=1, leave the pointer, RDATA and RVALID unchanged and pulse RUNDERFLOW=1 for one cycle.
REQ-026 SHALL register RLEVEL as gray2bin(WQ2) - next binary pointer, modulo 2**(ADDR_SIZE+1); the result ranges from 0 to 2**ADDR_SIZE.
REQ-027 SHALL register RAEMPTY as (the RLEVEL next-value <= AE_THRESH).
REQ-028 SHALL treat RLEVEL and REMPTY as conservative: a write appears no earlier than the 3rd RCLK edge after WPTR_GRAY changes.
REQ-029 SHALL, when a read and a write-pointer update happen in the same cycle, apply both; REMPTY reflects the next pointer against the current WQ2.
REQ-030 SHALL keep REMPTY and RLEVEL mutually consistent every cycle: REMPTY=1 if and only if RLEVEL=0.

Reset
REQ-031 SHALL, on a rising RCLK edge with RRST_N=0, clear RBIN, RPTR_GRAY, WQ1, WQ2, RDATA, RVALID, RLEVEL and RUNDERFLOW to 0, and set REMPTY=1 and RAEMPTY=1.
REQ-032 SHALL let reset override RINC and WPTR_GRAY in the same cycle.
REQ-033 SHALL apply reset during operation the same way, discarding any read in progress.
REQ-034 SHALL, after RRST_N returns to 1, re-synchronize WPTR_GRAY and reflect it within 3 edges.

Verification
REQ-035 SHALL cover: reset with WPTR_GRAY=0 -> RADDR=0, RPTR_GRAY=0, REMPTY=1, RAEMPTY=1, RLEVEL=0, RVALID=0.
REQ-036 SHALL cover: WPTR_GRAY changes 00000 -> 00001 -> REMPTY=0, RLEVEL=1, RAEMPTY=1 at the 3rd RCLK edge, and not earlier.
REQ-037 SHALL cover: with one word present, RINC=1 and RAM_RDATA=16'hA5A5 -> next edge RDATA=16'hA5A5, RVALID=1, RADDR=1, RPTR_GRAY=00001, REMPTY=1, RLEVEL=0; RVALID=0 on the following edge.
REQ-038 SHALL cover: RINC=1 while REMPTY=1 -> RUNDERFLOW=1 for one cycle, with RADDR, RPTR_GRAY, RDATA and RVALID=0 unchanged.
REQ-039 SHALL cover wrap-around: WPTR_GRAY=11000 (16 words) -> RLEVEL=16 and RAEMPTY=0; then 16 consecutive reads -> RADDR=0, RPTR_GRAY=11000, REMPTY=1, RLEVEL=0, and 16 RVALID pulses.
REQ-040 SHALL cover reset mid-operation: RRST_N=0 for one edge at RADDR=7 with WPTR_GRAY=gray(10) -> RADDR=0, REMPTY=1, RLEVEL=0; after release -> REMPTY=0 and RLEVEL=10 at the 3rd edge.
